alu_muldiv_unit: RTL
====================

# alu_muldiv_unit

Parametrised iterative multiply/divide unit holding the architectural HI/LO register pair for the MIPS pipeline. It sits beside the combinational 32-bit ALU in EX. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per start pulse and computes products and quotients with a radix-2 shift-add / restoring-divide datapath. Busy stalls the pipeline; Done marks HI/LO update.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits (min 4, even).
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request strobe; accepted only when Busy=0.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- A  input  WIDTH  rs operand / dividend / multiplicand / MTHI-MTLO source.
- B  input  WIDTH  rt operand / divisor / multiplier.
- Busy  output  1  iterative operation in progress.
- Done  output  1  one-cycle pulse: HI/LO just updated.
- HI  output  WIDTH  registered HI.
- LO  output  WIDTH  registered LO.
- DivByZero  output  1  last divide had B=0.

## Operation
- FSM: IDLE, CALC, FIX. Iteration counter width clog2(WIDTH+1).
- IDLE: Start=1 latches Op, magnitudes of A/B (signed ops) or raw A/B (unsigned), result signs; clears DivByZero; goes to CALC. Other ops are handled directly in IDLE.
- CALC: one iteration per cycle for exactly WIDTH cycles, then FIX.
  - Multiply: 2*WIDTH-bit shift-add.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply signs, write HI/LO, pulse Done, return to IDLE.
- Multiply: {HI,LO} = A*B, full 2*WIDTH-bit product, signed or unsigned.
- Divide: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes dividend's sign. Most-negative / -1: LO = most-negative, HI = 0.
- Divide by zero, B=0, still takes full latency: LO = all ones, HI = A, DivByZero=1. DivByZero holds until next accepted Start.
- MTHI/MTLO: HI (or LO) = A at the accepting edge. Other register unchanged. Busy stays 0. Done pulses the following cycle.
- MADD/MSUB without macro: illegal. HI/LO unchanged, Done pulses next cycle, Busy stays 0.
- Start while Busy=1: ignored, no queueing.
- Start in the Done cycle: accepted normally, back-to-back.

## Timing
- Reset (async assert, sync release): HI=0, LO=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately. No Done follows.
- Iterative op, Start sampled at edge E0:
  - Busy=1 after E0 through edge E(WIDTH+1).
  - HI/LO updated and Done=1 after E(WIDTH+1).
  - Busy=0 in the Done cycle.
  - Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Single-cycle ops (MTHI/MTLO/illegal): HI/LO valid and Done=1 after E0.
- HI/LO never change except at FIX or a single-cycle op edge. Intermediate values are never visible.

## Configuration
- MULDIV_MADD_EN defined: MADD/MSUB are signed multiply-accumulate with full WIDTH+1 latency.
  - MADD: {HI,LO} += A*B.
  - MSUB: {HI,LO} -= A*B.
  - Wraps modulo 2^(2*WIDTH).
  - Accumulation is applied in FIX.
- MULDIV_MADD_EN undefined: accumulator adder absent; opcodes 110/111 take the illegal path.

## Test plan
- MULTU A=100, B=101, WIDTH=32 -> Busy 33 cycles; then HI=0, LO=10100, Done high exactly one cycle.
- MULT A=-3, B=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU A=100, B=0 -> after 33 cycles LO=32'hFFFFFFFF, HI=100, DivByZero=1. Next accepted Start clears DivByZero.
- MTHI A=32'h12345678, then MTLO A=7 back-to-back -> HI=32'h12345678, LO=7. Busy never asserted; one Done per op.
- MULTU 100*101 with a second Start at cycle 5 -> second Start ignored, result 10100. Separately, Reset_n low at cycle 10 of a DIV -> HI=LO=0, Busy=0, no Done.
- With MULDIV_MADD_EN: MULTU 100*101, then MADD 2*3 -> LO=10106; MSUB 2*3 -> LO=10100. Without the macro, MADD -> HI/LO unchanged, Done after one cycle.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit owning the HI/LO pair.
// Define MULDIV_MADD_EN to enable signed MADD/MSUB accumulation into HI/LO.
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [PW-1:0]    p_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic             div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;
  logic             dbz_reg;
`ifdef MULDIV_MADD_EN
  logic             acc_reg;
  logic             sub_reg;
`endif

  // Request decode
  logic             start_iter;
  logic             start_signed;
  logic             start_div;
  logic             start_acc;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    start_iter   = 1'b0;
    start_signed = 1'b0;
    start_div    = 1'b0;
    start_acc    = 1'b0;
    case (Op)
      OP_MULT:  begin start_iter = 1'b1; start_signed = 1'b1; end
      OP_MULTU: begin start_iter = 1'b1; end
      OP_DIV:   begin start_iter = 1'b1; start_signed = 1'b1; start_div = 1'b1; end
      OP_DIVU:  begin start_iter = 1'b1; start_div = 1'b1; end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB: begin
        start_iter   = 1'b1;
        start_signed = 1'b1;
        start_acc    = 1'b1;
      end
`endif
      default: ;
    endcase
    a_mag = (start_signed && A[WIDTH-1]) ? ('0 - A) : A;
    b_mag = (start_signed && B[WIDTH-1]) ? ('0 - B) : B;
  end

  // One iteration of each datapath
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [PW-1:0]    div_next;

  always_comb begin
    mul_sum   = {1'b0, p_reg[PW-1:WIDTH]} + (p_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next  = {mul_sum, p_reg[WIDTH-1:1]};
    // Upper half holds the partial remainder, lower half shifts dividend out / quotient in
    div_shift = {p_reg[PW-1:WIDTH], p_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, p_reg[WIDTH-2:0], div_ge};
  end

  // Sign fix-up and final HI/LO values
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;
`ifdef MULDIV_MADD_EN
  logic [PW-1:0]    acc_sum;
`endif

  always_comb begin
    prod_fix = neg_q_reg ? ('0 - p_reg) : p_reg;
    quot_fix = neg_q_reg ? ('0 - p_reg[WIDTH-1:0]) : p_reg[WIDTH-1:0];
    rem_fix  = neg_r_reg ? ('0 - p_reg[PW-1:WIDTH]) : p_reg[PW-1:WIDTH];
    hi_fix   = prod_fix[PW-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_MADD_EN
    acc_sum  = sub_reg ? ({hi_reg, lo_reg} - prod_fix) : ({hi_reg, lo_reg} + prod_fix);
    if (acc_reg) begin
      hi_fix = acc_sum[PW-1:WIDTH];
      lo_fix = acc_sum[WIDTH-1:0];
    end
`endif
    if (div_reg) begin
      // A zero divisor leaves the dividend in the remainder, so HI already equals A
      hi_fix = rem_fix;
      lo_fix = dz_reg ? '1 : quot_fix;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start && start_iter) state_next = CALC;
      CALC:    if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_reg   <= '0;
      p_reg     <= '0;
      opnd_reg  <= '0;
      div_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_reg   <= 1'b0;
      sub_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            dbz_reg <= 1'b0;
            if (start_iter) begin
              cnt_reg   <= '0;
              div_reg   <= start_div;
              opnd_reg  <= start_div ? b_mag : a_mag;
              p_reg     <= {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
              neg_q_reg <= start_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_r_reg <= start_signed && A[WIDTH-1];
              dz_reg    <= start_div && (B == '0);
`ifdef MULDIV_MADD_EN
              acc_reg   <= start_acc;
              sub_reg   <= (Op == OP_MSUB);
`endif
            end else begin
              if (Op == OP_MTHI) hi_reg <= A;
              if (Op == OP_MTLO) lo_reg <= A;
              done_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          p_reg   <= div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          hi_reg   <= hi_fix;
          lo_reg   <= lo_fix;
          dbz_reg  <= dz_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Keeps the accumulate decode referenced when the adder is compiled out
  logic unused_acc;
  assign unused_acc = start_acc;

  assign Busy      = (state_reg != IDLE);
  assign Done      = done_reg;
  assign HI        = hi_reg;
  assign LO        = lo_reg;
  assign DivByZero = dbz_reg;

endmodule
